// File: rtl/shared_bus_rr_arb_pkg.sv
// Shared types for the round-robin shared-bus arbiter.
// Payload shape, FSM state encoding and beat counter width.
package shared_bus_rr_arb_pkg;

  localparam int BEAT_W = 8;

  typedef logic [4:1][0:3][1:2][4:3] payload_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/shared_bus_rr_arb_if.sv
// Requester/resource bundle for the shared-bus arbiter.
// slave: arbiter view; master: requesters plus shared resource.
interface shared_bus_rr_arb_if #(
  parameter int N_REQ = 3
);
  import shared_bus_rr_arb_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  last;
  payload_t          req_data [N_REQ-1:0];
  logic [N_REQ-1:0]  gnt;
  payload_t          bus_data;
  logic              bus_valid;
  logic              bus_ready;
  logic              preempt;
  logic [BEAT_W-1:0] beat_cnt;

  modport slave (
    input  req, last, req_data, bus_ready,
    output gnt, bus_data, bus_valid,
    output preempt, beat_cnt
  );

  modport master (
    output req, last, req_data, bus_ready,
    input  gnt, bus_data, bus_valid,
    input  preempt, beat_cnt
  );

endinterface

// File: rtl/shared_bus_rr_arb_rr_pick.sv
// Combinational round-robin select: lowest req index at or
// above ptr wins, wrapping. Out: one-hot, index, any-valid.
module rr_pick #(
  parameter  int N_REQ = 3,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_any
);

  always_comb begin : pick
    logic [IDX_W:0]   s;
    logic [IDX_W-1:0] k;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    s       = '0;
    k       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      s = {1'b0, ptr} + (IDX_W+1)'(i);
      if (s >= (IDX_W+1)'(N_REQ))
        s = s - (IDX_W+1)'(N_REQ);
      k = s[IDX_W-1:0];
      if (!win_any && req[k]) begin
        win_any    = 1'b1;
        win_oh[k]  = 1'b1;
        win_idx    = k;
      end
    end
  end

endmodule

// File: rtl/shared_bus_rr_arb.sv
// Round-robin arbiter granting one requester a shared bus per
// tenure. Ports: clk, rst_n, bus (slave view of the bundle).
module shared_bus_rr_arb
  import shared_bus_rr_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int MAX_BEATS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  shared_bus_rr_arb_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic              pre_q, pre_d;
  logic              rst_meta_q, arb_en_q;

  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              own;
  logic              xfer;
  logic              rel;
  logic [BEAT_W-1:0] cnt_inc;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_any (pick_any)
  );

  // Reset release is re-timed so arbitration waits two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      arb_en_q   <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      arb_en_q   <= rst_meta_q;
    end
  end

  assign own  = (state_q == ST_OWN);
  assign xfer = bus.bus_valid && bus.bus_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    rel     = 1'b0;
    cnt_inc = (cnt_q == '1) ? cnt_q
                            : cnt_q + BEAT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (arb_en_q && pick_any) begin
          state_d = ST_OWN;
          owner_d = pick_idx;
          gnt_d   = pick_oh;
          cnt_d   = '0;
        end
      end
      ST_OWN: begin
        if (xfer) begin
          if (bus.last[owner_q]) begin
            rel = 1'b1;
          end else if (cnt_inc == BEAT_W'(MAX_BEATS)) begin
            rel   = 1'b1;
            pre_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!bus.req[owner_q]) begin
          rel = 1'b1;
        end
        if (rel) begin
          state_d = ST_RELEASE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (owner_q == IDX_W'(N_REQ-1))
                    ? '0 : owner_q + IDX_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.preempt   = pre_q;
  assign bus.bus_valid = own && bus.req[owner_q];
  assign bus.bus_data  = own ? bus.req_data[owner_q]
                             : '0;

endmodule

// File: doc/shared_bus_rr_arb.md
SHARED_BUS_RR_ARB -- requirements
Module: shared_bus_rr_arb

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters (2..8).
REQ-002 Parameter MAX_BEATS, default 8, maximum beats per grant tenure (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  N_REQ  per-requester request; also valid for the presented beat.
REQ-006 last  input  N_REQ  per-requester end-of-burst marker, qualified by the owner's beat.
REQ-007 req_data  input  unpacked [N_REQ-1:0] of packed [4:1][0:3][1:2][4:3] logic  per-requester beat payload.
REQ-008 gnt  output  N_REQ  one-hot grant; all zero when no owner.
REQ-009 bus_data  output  packed [4:1][0:3][1:2][4:3] logic  shared resource write data.
REQ-010 bus_valid  output  1  beat present on the shared resource.
REQ-011 bus_ready  input  1  shared resource accepts the beat.
REQ-012 preempt  output  1  one-cycle pulse when a tenure is force-ended by MAX_BEATS.
REQ-013 beat_cnt  output  8  beats transferred in the current tenure.

Function
REQ-014 FSM states: IDLE, OWN, RELEASE.
- IDLE: if any req bit is set, select the owner round-robin starting at ptr, register it, enter OWN; else stay.
REQ-015 gnt SHALL be asserted from the cycle after selection; there is no combinational path from req to gnt.
REQ-016 In OWN: bus_valid = req[owner]; bus_data = req_data[owner] (combinational mux); a beat transfers when bus_valid && bus_ready.
REQ-017 On every transfer, beat_cnt increments by 1, saturating at 255.
REQ-018 OWN exits to RELEASE on any of the following; the first three take effect on the same edge as the transfer:
- a transfer with last[owner]=1;
- a transfer that makes beat_cnt equal MAX_BEATS while last[owner]=0, which also pulses preempt;
- the same as the preempt case when last[owner]=1, which is a normal release with no preempt;
- req[owner] deasserting with no transfer in that cycle.
REQ-019 RELEASE lasts one cycle.
- gnt=0, bus_valid=0, beat_cnt cleared.
- ptr = (owner+1) mod N_REQ.
- Next state is IDLE.
REQ-020 Round robin: the lowest index at or above ptr wins, wrapping past N_REQ-1 to 0; ptr initialises to 0.
REQ-021 While bus_ready=0, bus_data and bus_valid SHALL remain stable for as long as the owner holds req and req_data stable; the arbiter SHALL NOT alter gnt during a stall.
REQ-022 Requests from non-owners during OWN are ignored and not latched.
REQ-023 Minimum turnaround between tenures is 2 idle bus cycles (RELEASE, IDLE).

Reset
REQ-024 Asserting rst_n low at any time, including mid-tenure or a stalled beat, SHALL immediately apply:
- state=IDLE, ptr=0, gnt=0, bus_valid=0, bus_data=0, beat_cnt=0, preempt=0.
REQ-025 Deassertion is synchronised internally; the first arbitration occurs no earlier than the second rising edge after rst_n rises.

Structure
REQ-026 A shared package holds:
- the payload typedef (packed [4:1][0:3][1:2][4:3] logic);
- the FSM state enum;
- the beat_cnt width constant.
REQ-027 One sub-module, rr_pick, SHALL implement the combinational round-robin priority select (inputs: req, ptr; output: one-hot winner plus index).
REQ-028 All outputs are driven by exactly one continuous assign or one always_ff; no multiply-driven nets.

Verification
REQ-029 req=3'b111, bus_ready=1, each requester sends 2 beats with last on beat 2 -> grants in order 0,1,2, 2 beats each, 2-cycle gap between tenures.
REQ-030 req[1] held, last=0, MAX_BEATS=8, bus_ready=1 -> 8 transfers, preempt pulses on the 8th, then gnt[1] is re-granted after 2 cycles if req[1] is still high and no other requester is present.
REQ-031 Owner 0 with bus_ready=0 for 5 cycles -> bus_data and bus_valid stable, beat_cnt unchanged, gnt[0] held; transfer on the first ready cycle.
REQ-032 rst_n pulled low on the 3rd beat of a tenure -> all outputs 0 in the same cycle; after release, arbitration restarts at ptr=0.
REQ-033 ptr=2 with req=3'b011 -> requester 0 is granted (wrap-around); ptr becomes 1 afterwards.
REQ-034 Owner drops req mid-burst after 3 beats -> RELEASE with no preempt; beat_cnt returns to 0.
